reg_writeback_ctrl: RTL
=======================

Name: reg_writeback_ctrl

Overview:
- Write-side controller for the 8-bit register file.
- Collects results from the ALU (single-cycle) and from data memory (variable-latency loads).
- Issues at most one register write per cycle on waddr/data_out; waddr = 5'b10000 means "no write".
- Tracks the one outstanding load and flags read-after-write hazards so decode can stall.

Parameters:
FIFO_DEPTH, 2, number of buffered ALU results awaiting write port (power of 2)
TIMEOUT, 16, max cycles in WAIT_MEM before a load is abandoned
NOWR, 5'b10000, waddr encoding for "no write"

Ports:
CLK  input  1  clock
reset  input  1  synchronous, active-high
alu_valid  input  1  ALU result valid this cycle
alu_dest  input  5  ALU destination register (NOWR = discard)
alu_result  input  8  ALU result data
load_req  input  1  load issued to memory this cycle
load_dest  input  5  load destination register
mem_ready  input  1  memory read data valid
mem_data  input  8  memory read data
raddrA  input  5  decode read address A (hazard check)
rAddrB  input  5  decode read address B (hazard check)
waddr  output  5  register-file write address, registered
data_out  output  8  register-file write data, registered
stall  output  1  upstream must hold ALU/load issue
hazard  output  1  a read address matches a pending write
pend_valid  output  1  load outstanding
err  output  1  one-cycle pulse: load timeout or FIFO overflow

Behaviour:
- Reset: waddr=NOWR, data_out=8'h00, FIFO empty, state IDLE, pend_valid=0, timeout counter=0, err=0. Reset mid-load drops the load; a later mem_ready is ignored.
- FSM states:
  - IDLE -> WAIT_MEM on load_req while not stalled; captures pend_dest, clears squash, counter=0.
  - WAIT_MEM -> IDLE on mem_ready.
  - WAIT_MEM -> IDLE when the counter reaches TIMEOUT-1 without mem_ready: err pulses next cycle, no write.
  - mem_ready in IDLE: ignored.
- Write-port selection, one per cycle, priority order:
  1. Memory response: mem_ready in WAIT_MEM, not squashed, pend_dest != NOWR.
  2. FIFO head.
  3. Incoming alu_valid, only if FIFO empty.
- Selected write appears on waddr/data_out at the next posedge (1-cycle latency); the register file commits on the following edge.
- Cycles with no selection drive waddr=NOWR, data_out holds its last value.
- Unselected alu_valid with alu_dest != NOWR is pushed into the FIFO; alu_dest=NOWR is dropped silently.
- A FIFO pop and push in the same cycle is legal; count is unchanged.
- stall (combinational) = (FIFO count == FIFO_DEPTH) | (pend_valid & load_req).
- alu_valid while FIFO full: sample dropped, err pulses next cycle.
- load_req while pend_valid: not accepted; upstream re-presents it.
- Same-cycle mem_ready + load_req in WAIT_MEM: response completes; load_req is stalled, then accepted the next cycle from IDLE.
- WAW squash: alu_valid with alu_dest == pend_dest (!= NOWR) while WAIT_MEM sets squash.
  - Response is consumed (IDLE) without writing; the younger ALU value wins.
  - Also applies if alu_valid and mem_ready coincide.
- hazard (combinational): pend_valid & pend_dest != NOWR & (raddrA==pend_dest | rAddrB==pend_dest), OR any valid FIFO entry dest equals raddrA/rAddrB, OR waddr != NOWR matches either read address.
- pend_valid = (state == WAIT_MEM).
- Counter saturates; it is cleared on every accepted load.

Test Plan:
- ALU only: alu_valid, dest=3, result=8'h5A, FIFO empty -> next cycle waddr=3, data_out=8'h5A; following idle cycle waddr=NOWR.
- Load latency 4: load_req dest=7; mem_ready, mem_data=8'hC3 after 4 cycles -> pend_valid high 4 cycles; waddr=7/data_out=8'hC3 one cycle after mem_ready; raddrA=7 gives hazard=1 while pending.
- Collision: mem_ready (dest 7, 8'h11) with alu_valid (dest 2, 8'h22) -> cycle N+1 writes 7/8'h11, cycle N+2 writes 2/8'h22 from FIFO.
- FIFO full: hold mem priority with FIFO at 2 entries -> stall=1; a forced third alu_valid is dropped and err pulses once.
- Squash: load dest=5, then alu_valid dest=5 value 8'hAA, then mem_ready 8'hBB -> only 5/8'hAA written, never 8'hBB.
- Timeout/reset: load_req, no mem_ready for 16 cycles -> IDLE, err pulse, no write. Separately, reset mid-WAIT_MEM then mem_ready -> no write, pend_valid=0.

Source files
------------

// File: rtl/reg_writeback_ctrl.sv
// rtl/reg_writeback_ctrl.sv - write-side controller for the 8-bit register file
//
// Merges single-cycle ALU results and variable-latency load responses onto a
// single registered write port. Tracks one outstanding load, buffers ALU
// results that lose arbitration, and flags read-after-write hazards.
//
// Ports:
//   CLK, reset            clock, synchronous active-high reset
//   alu_valid/dest/result ALU result offered this cycle (dest NOWR = discard)
//   load_req/load_dest    load issued to memory this cycle
//   mem_ready/mem_data    memory read data valid
//   raddrA, rAddrB        decode read addresses checked for hazards
//   waddr, data_out       registered write port (waddr NOWR = no write)
//   stall                 upstream must hold ALU/load issue
//   hazard                a read address matches a pending write
//   pend_valid            a load is outstanding
//   err                   one-cycle pulse on load timeout or FIFO overflow

module reg_writeback_ctrl #(
    parameter int         FIFO_DEPTH = 2,
    parameter int         TIMEOUT    = 16,
    parameter logic [4:0] NOWR       = 5'b10000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       alu_valid,
    input  logic [4:0] alu_dest,
    input  logic [7:0] alu_result,
    input  logic       load_req,
    input  logic [4:0] load_dest,
    input  logic       mem_ready,
    input  logic [7:0] mem_data,
    input  logic [4:0] raddrA,
    input  logic [4:0] rAddrB,
    output logic [4:0] waddr,
    output logic [7:0] data_out,
    output logic       stall,
    output logic       hazard,
    output logic       pend_valid,
    output logic       err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [4:0]    pend_dest;
    logic          squash_q;
    logic [TW-1:0] tcnt;

    logic [4:0]    fifo_dest [FIFO_DEPTH];
    logic [7:0]    fifo_data [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;

    logic load_accept, mem_done, timeout_hit;
    logic fifo_empty, fifo_full;
    logic squash_now, mem_sel, fifo_sel, alu_sel;
    logic alu_keep, push_want, push, pop, overflow;
    logic [4:0] wr_dest;
    logic [7:0] wr_data;
    logic wr_en;
    logic pend_hit, fifo_hit, port_hit;
    logic [PW-1:0] idx;

    assign pend_valid = (state_q == WAIT_MEM);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign stall      = fifo_full | (pend_valid & load_req);

    // Next-state logic. mem_ready always completes the load, even if it is
    // squashed; a same-cycle load_req is stalled and retried from IDLE.
    always_comb begin
        state_d     = state_q;
        load_accept = 1'b0;
        mem_done    = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_req && !stall) begin
                    state_d     = WAIT_MEM;
                    load_accept = 1'b1;
                end
            end
            WAIT_MEM: begin
                if (mem_ready) begin
                    state_d  = IDLE;
                    mem_done = 1'b1;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    state_d     = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A younger ALU write to the pending destination makes the load result
    // stale; squash_now covers the ALU write landing in the response cycle.
    always_comb begin
        squash_now = pend_valid && alu_valid && (alu_dest == pend_dest) && (pend_dest != NOWR);
        mem_sel    = mem_done && !squash_q && !squash_now && (pend_dest != NOWR);
        fifo_sel   = !mem_sel && !fifo_empty;
        alu_keep   = alu_valid && (alu_dest != NOWR);
        alu_sel    = !mem_sel && fifo_empty && alu_keep;
        push_want  = alu_keep && !alu_sel;
        // A full FIFO drops the sample even if the head pops this cycle.
        push       = push_want && !fifo_full;
        overflow   = push_want && fifo_full;
        pop        = fifo_sel;
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_dest = NOWR;
        wr_data = 8'h00;
        if (mem_sel) begin
            wr_en   = 1'b1;
            wr_dest = pend_dest;
            wr_data = mem_data;
        end else if (fifo_sel) begin
            wr_en   = 1'b1;
            wr_dest = fifo_dest[rd_ptr];
            wr_data = fifo_data[rd_ptr];
        end else if (alu_sel) begin
            wr_en   = 1'b1;
            wr_dest = alu_dest;
            wr_data = alu_result;
        end
    end

    // Write port: data_out holds its last value on idle cycles.
    always_ff @(posedge CLK) begin
        if (reset) begin
            waddr    <= NOWR;
            data_out <= 8'h00;
        end else if (wr_en) begin
            waddr    <= wr_dest;
            data_out <= wr_data;
        end else begin
            waddr    <= NOWR;
        end
    end

    // Load tracking: destination, squash flag and saturating timeout counter.
    always_ff @(posedge CLK) begin
        if (reset) begin
            pend_dest <= NOWR;
            squash_q  <= 1'b0;
            tcnt      <= '0;
            err       <= 1'b0;
        end else begin
            err <= timeout_hit | overflow;
            if (load_accept) begin
                pend_dest <= load_dest;
                squash_q  <= 1'b0;
                tcnt      <= '0;
            end else begin
                if (squash_now) begin
                    squash_q <= 1'b1;
                end
                if (pend_valid && (tcnt != TW'(TIMEOUT - 1))) begin
                    tcnt <= tcnt + TW'(1);
                end
            end
        end
    end

    // ALU result FIFO.
    always_ff @(posedge CLK) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_dest[wr_ptr] <= alu_dest;
                fifo_data[wr_ptr] <= alu_result;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Hazard: outstanding load, any buffered ALU result, or the write in flight.
    always_comb begin
        pend_hit = pend_valid && (pend_dest != NOWR) &&
                   ((raddrA == pend_dest) || (rAddrB == pend_dest));
        fifo_hit = 1'b0;
        idx      = rd_ptr;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if ((fifo_dest[idx] == raddrA) || (fifo_dest[idx] == rAddrB)) begin
                    fifo_hit = 1'b1;
                end
            end
        end
        port_hit = (waddr != NOWR) && ((waddr == raddrA) || (waddr == rAddrB));
        hazard   = pend_hit | fifo_hit | port_hit;
    end

endmodule
